// File: rtl/alu_seq_pkg.sv
// Shared constants for the multi-word add/sub sequencer: ALU command codes,
// ALU status-register bit positions and the sequencer state encoding.
package alu_seq_pkg;

    // ALU command codes understood by the external 32-bit ALU
    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] ADC = 4'b0011;
    localparam logic [3:0] SUB = 4'b0100;
    localparam logic [3:0] SBC = 4'b0101;

    // Bit positions inside the ALU status word {Z,C,N,V}
    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mw_sequencer.sv
// Multi-word add/sub sequencer. Streams operand word pairs (LS word first)
// through one shared combinational 32-bit ALU, chaining carry/borrow from
// the ALU status register, and returns result words through a one-entry
// output register plus combined {Z,C,N,V} flags on the final word.
module alu_mw_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NWORDS_MAX = 4,
    parameter int LW         = $clog2(NWORDS_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          start_op,
    input  logic [LW-1:0] start_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    output logic [3:0]    alu_cmd,
    output logic [31:0]   alu_val1,
    output logic [31:0]   alu_val2,
    output logic          alu_c,
    input  logic [31:0]   alu_out,
    input  logic [3:0]    alu_sr,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_data,
    output logic          res_last,
    output logic [3:0]    res_flags,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          op_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt_q;
    logic          carry_q;
    logic          zacc_q;
    logic          res_valid_q;
    logic          res_last_q;
    logic [31:0]   res_data_q;
    logic [3:0]    res_flags_q;

    logic          start_fire;
    logic          accept;
    logic          out_fire;
    logic          last_word;

    // A requested length of zero means one word; anything above the maximum saturates.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len == '0) begin
            return LW'(1);
        end else if (len > LW'(NWORDS_MAX)) begin
            return LW'(NWORDS_MAX);
        end else begin
            return len;
        end
    endfunction

    assign start_fire = (state_q == IDLE) && start_valid;
    assign accept     = in_valid && in_ready;
    assign out_fire   = res_valid_q && res_ready;
    assign last_word  = (cnt_q == (len_q - LW'(1)));

    // Operands go straight to the ALU; the sequencer only chooses command and carry-in.
    assign alu_val1 = in_a;
    assign alu_val2 = in_b;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN until the last pair is taken, DRAIN until its result leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid)             state_d = RUN;
            RUN:     if (accept && last_word)     state_d = DRAIN;
            DRAIN:   if (out_fire)                state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Output logic: ALU command selection, carry-in polarity and handshake readiness.
    always_comb begin
        alu_cmd     = NOP;
        in_ready    = 1'b0;
        alu_c       = op_q ? ~carry_q : carry_q;
        start_ready = (state_q == IDLE);
        busy        = (state_q != IDLE);
        if (state_q == RUN) begin
            in_ready = !res_valid_q || res_ready;
            if (cnt_q == '0) begin
                alu_cmd = op_q ? SUB : ADD;
            end else begin
                alu_cmd = op_q ? SBC : ADC;
            end
        end
    end

    // Datapath: latch the request, chain carry and zero through each accepted word,
    // and keep the one-entry result register full until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= 1'b0;
            len_q       <= LW'(1);
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b1;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else begin
            if (start_fire) begin
                op_q   <= start_op;
                len_q  <= clamp_len(start_len);
                cnt_q  <= '0;
                zacc_q <= 1'b1;
            end
            if (accept) begin
                res_data_q  <= alu_out;
                res_valid_q <= 1'b1;
                res_last_q  <= last_word;
                carry_q     <= alu_sr[SR_C];
                zacc_q      <= zacc_q & alu_sr[SR_Z];
                res_flags_q <= {zacc_q & alu_sr[SR_Z], alu_sr[SR_C], alu_sr[SR_N], alu_sr[SR_V]};
                cnt_q       <= cnt_q + LW'(1);
            end else if (out_fire) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;
    assign res_flags = res_flags_q;

endmodule

// File: tb/tb_alu_mw_sequencer.sv
// Bench for alu_mw_sequencer: provides a behavioural 32-bit ALU on the alu_*
// ports, runs a table of directed operations, hand-written multi-cycle
// sequences (command/carry chaining, backpressure, reset abort) and random
// operations compared against a whole-number reference model.
module tb_alu_mw_sequencer;

    localparam int LW = 3;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic          start_op;
    logic [LW-1:0] start_len;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic [3:0]    alu_cmd;
    logic [31:0]   alu_val1;
    logic [31:0]   alu_val2;
    logic          alu_c;
    logic [31:0]   alu_out;
    logic [3:0]    alu_sr;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic          res_last;
    logic [3:0]    res_flags;
    logic          busy;

    int testCount = 0;
    int failCount = 0;

    alu_mw_sequencer #(.NWORDS_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_op    (start_op),
        .start_len   (start_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .alu_cmd     (alu_cmd),
        .alu_val1    (alu_val1),
        .alu_val2    (alu_val2),
        .alu_c       (alu_c),
        .alu_out     (alu_out),
        .alu_sr      (alu_sr),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last),
        .res_flags   (res_flags),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU: SUB/SBC report borrow in C, SBC computes a-b-~C.
    logic [32:0] aluWide;
    logic        aluIsSub;
    always_comb begin
        aluWide  = '0;
        aluIsSub = 1'b0;
        case (alu_cmd)
            4'b0010: aluWide = {1'b0, alu_val1} + {1'b0, alu_val2};
            4'b0011: aluWide = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'b0, alu_c};
            4'b0100: begin aluWide = {1'b0, alu_val1} - {1'b0, alu_val2}; aluIsSub = 1'b1; end
            4'b0101: begin aluWide = {1'b0, alu_val1} - {1'b0, alu_val2} - {32'b0, ~alu_c}; aluIsSub = 1'b1; end
            default: aluWide = '0;
        endcase
        alu_out   = aluWide[31:0];
        alu_sr[3] = (aluWide[31:0] == 32'b0);
        alu_sr[2] = aluWide[32];
        alu_sr[1] = aluWide[31];
        if (alu_cmd == 4'b0000)
            alu_sr[0] = 1'b0;
        else if (aluIsSub)
            alu_sr[0] = (alu_val1[31] != alu_val2[31]) && (aluWide[31] != alu_val1[31]);
        else
            alu_sr[0] = (alu_val1[31] == alu_val2[31]) && (aluWide[31] != alu_val1[31]);
    end

    typedef struct {
        bit           op;
        logic [2:0]   len;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] expRes;
        int           expN;
        logic [3:0]   expFlags;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Whole-number view of a multi-word add/sub: result, word count and {Z,C,N,V}.
    function automatic void model(input bit op, input logic [2:0] lenIn,
                                  input logic [127:0] a, input logic [127:0] b,
                                  output logic [127:0] res, output logic [3:0] fl, output int n);
        logic [128:0] mask;
        logic [128:0] wide;
        logic [127:0] am, bm;
        logic         c;
        int           top;
        n    = (lenIn == 0) ? 1 : ((lenIn > 4) ? 4 : int'(lenIn));
        mask = (129'b1 << (32 * n)) - 129'b1;
        am   = a & mask[127:0];
        bm   = b & mask[127:0];
        if (!op) begin
            wide = {1'b0, am} + {1'b0, bm};
            c    = wide[32 * n];
            res  = wide[127:0] & mask[127:0];
        end else begin
            res = (am - bm) & mask[127:0];
            c   = (am < bm);
        end
        top   = 32 * n - 1;
        fl[3] = (res == 128'b0);
        fl[2] = c;
        fl[1] = res[top];
        if (!op)
            fl[0] = (am[top] == bm[top]) && (res[top] != am[top]);
        else
            fl[0] = (am[top] != bm[top]) && (res[top] != am[top]);
    endfunction

    // Runs one full operation: start, stream pairs, collect results until the last word leaves.
    task automatic applyStimulus(input bit op, input logic [2:0] lenIn,
                                 input logic [127:0] a, input logic [127:0] b,
                                 input int bpPct, input int stall,
                                 output logic [127:0] got, output int gotN, output logic [3:0] flags);
        int         n;
        int         fed;
        int         stallLeft;
        bit         done;
        bit         started;
        logic [3:0] capCmd;
        logic [31:0] capV1, capV2;
        logic       capC;
        n         = (lenIn == 0) ? 1 : ((lenIn > 4) ? 4 : int'(lenIn));
        got       = '0;
        gotN      = 0;
        flags     = '0;
        fed       = 0;
        stallLeft = stall;
        done      = 1'b0;
        started   = 1'b0;
        capCmd = '0; capV1 = '0; capV2 = '0; capC = 1'b0;

        @(negedge clk);
        start_valid = 1'b1;
        start_op    = op;
        start_len   = lenIn;
        in_valid    = 1'b0;
        res_ready   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (start_ready) begin started = 1'b1; break; end
            @(negedge clk);
        end
        if (!started) begin
            checkOutput("start_timeout", 128'd0, 128'd1);
            start_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (stallLeft > 0 && res_valid && gotN == 0) begin
                res_ready = 1'b0;
                in_valid  = (fed < n);
                in_a      = a[32 * fed +: 32];
                in_b      = b[32 * fed +: 32];
                #1;
                checkOutput("stall_in_ready", in_ready, 0);
                if (stallLeft == stall) begin
                    capCmd = alu_cmd; capV1 = alu_val1; capV2 = alu_val2; capC = alu_c;
                end else begin
                    checkOutput("stall_cmd", alu_cmd, capCmd);
                    checkOutput("stall_val1", alu_val1, capV1);
                    checkOutput("stall_val2", alu_val2, capV2);
                    checkOutput("stall_c", alu_c, capC);
                end
                stallLeft--;
            end else begin
                res_ready = ($urandom_range(0, 99) >= bpPct);
                in_valid  = (fed < n) && ($urandom_range(0, 99) < 80);
                in_a      = (fed < n) ? a[32 * fed +: 32] : $urandom;
                in_b      = (fed < n) ? b[32 * fed +: 32] : $urandom;
                #1;
            end
            if (res_valid && res_ready) begin
                if (gotN < 4) got[32 * gotN +: 32] = res_data;
                gotN++;
                if (res_last) begin
                    flags = res_flags;
                    done  = 1'b1;
                end
            end
            if (in_valid && in_ready) fed++;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        if (!done) checkOutput("op_timeout", 128'd0, 128'd1);
    endtask

    // Two-word operation stepped by hand to observe command codes and carry-in per word.
    task automatic cmdSeq(input string tag, input bit op,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input logic [3:0] cmd0, input logic [3:0] cmd1, input logic c1,
                          input logic [31:0] r0, input logic [31:0] r1, input logic [3:0] fl);
        @(negedge clk);
        start_valid = 1'b1; start_op = op; start_len = 3'd2;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        in_valid = 1'b1; in_a = a0; in_b = b0; res_ready = 1'b1;
        #1;
        checkOutput({tag, "_cmd0"}, alu_cmd, cmd0);
        checkOutput({tag, "_val1"}, alu_val1, a0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_res0"}, res_data, r0);
        checkOutput({tag, "_last0"}, res_last, 0);
        in_a = a1; in_b = b1;
        #1;
        checkOutput({tag, "_cmd1"}, alu_cmd, cmd1);
        checkOutput({tag, "_c1"}, alu_c, c1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_res1"}, res_data, r1);
        checkOutput({tag, "_last1"}, res_last, 1);
        checkOutput({tag, "_flags"}, res_flags, fl);
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_idle_valid"}, res_valid, 0);
        checkOutput({tag, "_idle_cmd"}, alu_cmd, 4'b0000);
    endtask

    initial begin
        logic [127:0] got, expRes;
        logic [3:0]   flags, expFlags;
        int           gotN, expN;
        bit           rop;
        logic [2:0]   rlen;
        logic [127:0] ra, rb;

        vecs[0] = '{op:0, len:3'd1, a:128'd5, b:128'd7, expRes:128'hC, expN:1, expFlags:4'b0000};
        vecs[1] = '{op:0, len:3'd2, a:128'h00000000_FFFFFFFF, b:128'd1,
                    expRes:128'h00000001_00000000, expN:2, expFlags:4'b0000};
        vecs[2] = '{op:1, len:3'd2, a:128'h00000001_00000000, b:128'd1,
                    expRes:128'h00000000_FFFFFFFF, expN:2, expFlags:4'b0000};
        vecs[3] = '{op:1, len:3'd4, a:128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,
                    b:128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, expRes:128'd0, expN:4, expFlags:4'b1000};
        vecs[4] = '{op:0, len:3'd0, a:128'hFFFFFFFF, b:128'd1, expRes:128'd0, expN:1, expFlags:4'b1100};
        vecs[5] = '{op:0, len:3'd7, a:128'h7FFFFFFF_00000000_00000000_00000001,
                    b:128'h00000001_00000000_00000000_00000001,
                    expRes:128'h80000000_00000000_00000000_00000002, expN:4, expFlags:4'b0011};
        vecs[6] = '{op:1, len:3'd1, a:128'd0, b:128'd1, expRes:128'hFFFFFFFF, expN:1, expFlags:4'b0110};
        vecs[7] = '{op:1, len:3'd1, a:128'h80000000, b:128'd1, expRes:128'h7FFFFFFF, expN:1, expFlags:4'b0001};

        rst_n = 1'b0; start_valid = 1'b0; start_op = 1'b0; start_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_start_ready", start_ready, 1);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_flags", res_flags, 0);
        checkOutput("rst_res_last", res_last, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].len, vecs[i].a, vecs[i].b, 30, 0, got, gotN, flags);
            checkOutput($sformatf("vec%0d_count", i), gotN, vecs[i].expN);
            checkOutput($sformatf("vec%0d_data", i), got, vecs[i].expRes);
            checkOutput($sformatf("vec%0d_flags", i), flags, vecs[i].expFlags);
        end

        cmdSeq("add2", 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0010, 4'b0011, 1'b1,
               32'h0, 32'h1, 4'b0000);
        cmdSeq("sub2", 1'b1, 32'h0, 32'h1, 32'h1, 32'h0, 4'b0100, 4'b0101, 1'b0,
               32'hFFFFFFFF, 32'h0, 4'b0000);

        applyStimulus(1'b0, 3'd3, 128'h00000003_FFFFFFFF_FFFFFFFF, 128'h00000004_00000000_00000001,
                      0, 5, got, gotN, flags);
        checkOutput("stall_count", gotN, 3);
        checkOutput("stall_data", got, 128'h00000008_00000000_00000000);
        checkOutput("stall_flags", flags, 4'b0000);

        // Abort an operation halfway through with reset.
        @(negedge clk);
        start_valid = 1'b1; start_op = 1'b0; start_len = 3'd4;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        in_valid = 1'b1; in_a = 32'h11; in_b = 32'h22; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'h33; in_b = 32'h44;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; res_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_res_valid", res_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_start_ready", start_ready, 1);
        checkOutput("abort_res_data", res_data, 0);
        checkOutput("abort_res_last", res_last, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd1, 128'd1, 128'd1, 0, 0, got, gotN, flags);
        checkOutput("post_abort_count", gotN, 1);
        checkOutput("post_abort_data", got, 128'd2);

        for (int t = 0; t < 40; t++) begin
            rop  = $urandom_range(0, 1);
            rlen = 3'($urandom_range(0, 7));
            ra   = {$urandom, $urandom, $urandom, $urandom};
            rb   = {$urandom, $urandom, $urandom, $urandom};
            if (t % 8 == 3) rb = ra;
            model(rop, rlen, ra, rb, expRes, expFlags, expN);
            applyStimulus(rop, rlen, ra, rb, $urandom_range(0, 60), 0, got, gotN, flags);
            checkOutput($sformatf("rnd%0d_count", t), gotN, expN);
            checkOutput($sformatf("rnd%0d_data", t), got, expRes);
            checkOutput($sformatf("rnd%0d_flags", t), flags, expFlags);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
